// File: rtl/seq_div16.sv
// seq_div16: multi-cycle restoring divider, one quotient bit per clock.
// Define SEQ_DIV16_SIGNED_EN for two's-complement truncating division.
module seq_div16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZDIV = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             div0;
  logic [WIDTH:0]   shift;
  logic [WIDTH:0]   trial;
  logic             fit;
  logic [WIDTH:0]   r_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic             ovf_res;

`ifdef SEQ_DIV16_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic sovf_q, sovf_d;
  logic min_neg1;

  assign dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign min_neg1 = (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                  && (divisor == {WIDTH{1'b1}});
  assign q_res    = qneg_q ? -q_nx : q_nx;
  assign r_res    = rneg_q ? -r_nx[WIDTH-1:0] : r_nx[WIDTH-1:0];
  assign ovf_res  = sovf_q;
`else
  assign dvd_mag  = dividend;
  assign dvs_mag  = divisor;
  assign q_res    = q_nx;
  assign r_res    = r_nx[WIDTH-1:0];
  assign ovf_res  = 1'b0;
`endif

  assign div0  = (divisor == '0);
  assign shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial = shift - {1'b0, dvs_q};
  assign fit   = ~trial[WIDTH];
  assign r_nx  = fit ? trial : shift;
  assign q_nx  = {q_q[WIDTH-2:0], fit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = div0 ? ZDIV : RUN;
      end
      RUN: begin
        if (cnt_q == '0) state_d = IDLE;
      end
      ZDIV: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_d    = r_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    dvs_d  = dvs_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
`ifdef SEQ_DIV16_SIGNED_EN
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    sovf_d = sovf_q;
`endif
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          r_d   = '0;
          cnt_d = CW'(WIDTH-1);
          dvs_d = dvs_mag;
          // a zero divisor keeps the raw dividend for the remainder
          q_d   = div0 ? dividend : dvd_mag;
`ifdef SEQ_DIV16_SIGNED_EN
          qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d = dividend[WIDTH-1];
          sovf_d = min_neg1;
`endif
        end
      end
      (state_q == RUN): begin
        r_d   = r_nx;
        q_d   = q_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quot_d = q_res;
          rem_d  = r_res;
          dbz_d  = 1'b0;
          zero_d = (q_res == '0);
          ovf_d  = ovf_res;
          done_d = 1'b1;
        end
      end
      (state_q == ZDIV): begin
        quot_d = '1;
        rem_d  = q_q;
        dbz_d  = 1'b1;
        zero_d = 1'b0;
        ovf_d  = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      dvs_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      dvs_q  <= dvs_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

`ifdef SEQ_DIV16_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      sovf_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      sovf_q <= sovf_d;
    end
  end
`endif

  always_comb begin
    busy        = (state_q != IDLE);
    done        = done_q;
    quotient    = quot_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
    zero        = zero_q;
    overflow    = ovf_q;
  end

endmodule
